// File: rtl/mc_cu_pkg.sv
`default_nettype none
//============================================================================
// Module   : mc_cu_pkg
// Brief    : Shared encodings for the multicycle MIPS-subset control unit.
// Revision : 1.0  initial release
//============================================================================
package mc_cu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // ALU operation codes
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0100;
    localparam logic [3:0] c_ALU_AND  = 4'b0001;
    localparam logic [3:0] c_ALU_OR   = 4'b0101;
    localparam logic [3:0] c_ALU_XOR  = 4'b0010;
    localparam logic [3:0] c_ALU_LUI  = 4'b0110;
    localparam logic [3:0] c_ALU_SLL  = 4'b0011;
    localparam logic [3:0] c_ALU_SRL  = 4'b0111;
    localparam logic [3:0] c_ALU_SRA  = 4'b1111;
    localparam logic [3:0] c_ALU_SLT  = 4'b1001;
    localparam logic [3:0] c_ALU_SLTU = 4'b1011;
    localparam logic [3:0] c_ALU_NOR  = 4'b1010;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_SRA   = 6'h03;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [5:0] c_FN_SLTU  = 6'h2B;

    localparam logic [1:0] c_ALUB_REG  = 2'b00;
    localparam logic [1:0] c_ALUB_FOUR = 2'b01;
    localparam logic [1:0] c_ALUB_IMM  = 2'b10;
    localparam logic [1:0] c_ALUB_IMM4 = 2'b11;

    localparam logic [1:0] c_PC_ALU    = 2'b00;
    localparam logic [1:0] c_PC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PC_REGA   = 2'b10;
    localparam logic [1:0] c_PC_JUMP   = 2'b11;

    typedef struct packed {
        logic op_add;
        logic op_sub;
        logic op_and;
        logic op_or;
        logic op_xor;
        logic op_nor;
        logic op_slt;
        logic op_sltu;
        logic op_sll;
        logic op_srl;
        logic op_sra;
        logic op_jr;
        logic op_addi;
        logic op_andi;
        logic op_ori;
        logic op_xori;
        logic op_lui;
        logic op_slti;
        logic op_sltiu;
        logic op_lw;
        logic op_sw;
        logic op_beq;
        logic op_bne;
        logic op_j;
        logic op_jal;
    } inst_t;

endpackage
`default_nettype wire

// File: rtl/mc_cu_decode.sv
`default_nettype none
//============================================================================
// Module   : mc_cu_decode
// Brief    : Combinational instruction decoder: one-hot flags, classes, ALU op.
// Revision : 1.0  initial release
//============================================================================
module mc_cu_decode
    import mc_cu_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output inst_t      o_inst,
    output logic [3:0] o_aluc,
    output logic       o_regrt,
    output logic       o_sext,
    output logic       o_shift,
    output logic       o_rtype,
    output logic       o_itype,
    output logic       o_load,
    output logic       o_store,
    output logic       o_branch,
    output logic       o_jump,
    output logic       o_illegal
);

    logic w_ext_en;
    logic w_r;

    generate
        if (EXT_ISA) begin : g_ext
            assign w_ext_en = 1'b1;
        end else begin : g_no_ext
            assign w_ext_en = 1'b0;
        end
    endgenerate

    assign w_r = (i_op == c_OP_RTYPE);

    always_comb begin
        o_inst          = '0;
        o_inst.op_add   = w_r && (i_func == c_FN_ADD);
        o_inst.op_sub   = w_r && (i_func == c_FN_SUB);
        o_inst.op_and   = w_r && (i_func == c_FN_AND);
        o_inst.op_or    = w_r && (i_func == c_FN_OR);
        o_inst.op_xor   = w_r && (i_func == c_FN_XOR);
        o_inst.op_nor   = w_r && (i_func == c_FN_NOR)  && w_ext_en;
        o_inst.op_slt   = w_r && (i_func == c_FN_SLT)  && w_ext_en;
        o_inst.op_sltu  = w_r && (i_func == c_FN_SLTU) && w_ext_en;
        o_inst.op_sll   = w_r && (i_func == c_FN_SLL);
        o_inst.op_srl   = w_r && (i_func == c_FN_SRL);
        o_inst.op_sra   = w_r && (i_func == c_FN_SRA);
        o_inst.op_jr    = w_r && (i_func == c_FN_JR);
        o_inst.op_addi  = (i_op == c_OP_ADDI);
        o_inst.op_andi  = (i_op == c_OP_ANDI);
        o_inst.op_ori   = (i_op == c_OP_ORI);
        o_inst.op_xori  = (i_op == c_OP_XORI);
        o_inst.op_lui   = (i_op == c_OP_LUI);
        o_inst.op_slti  = (i_op == c_OP_SLTI)  && w_ext_en;
        o_inst.op_sltiu = (i_op == c_OP_SLTIU) && w_ext_en;
        o_inst.op_lw    = (i_op == c_OP_LW);
        o_inst.op_sw    = (i_op == c_OP_SW);
        o_inst.op_beq   = (i_op == c_OP_BEQ);
        o_inst.op_bne   = (i_op == c_OP_BNE);
        o_inst.op_j     = (i_op == c_OP_J);
        o_inst.op_jal   = (i_op == c_OP_JAL);
    end

    assign o_shift  = o_inst.op_sll | o_inst.op_srl | o_inst.op_sra;
    assign o_rtype  = o_inst.op_add | o_inst.op_sub | o_inst.op_and | o_inst.op_or
                    | o_inst.op_xor | o_inst.op_nor | o_inst.op_slt | o_inst.op_sltu
                    | o_shift;
    assign o_itype  = o_inst.op_addi | o_inst.op_andi | o_inst.op_ori | o_inst.op_xori
                    | o_inst.op_lui | o_inst.op_slti | o_inst.op_sltiu;
    assign o_load   = o_inst.op_lw;
    assign o_store  = o_inst.op_sw;
    assign o_branch = o_inst.op_beq | o_inst.op_bne;
    assign o_jump   = o_inst.op_j | o_inst.op_jal | o_inst.op_jr;
    assign o_regrt  = o_itype | o_load;
    assign o_sext   = o_inst.op_addi | o_inst.op_slti | o_inst.op_sltiu
                    | o_load | o_store | o_branch;

    // Anything outside every class (including disabled extensions) is illegal
    assign o_illegal = ~(o_rtype | o_itype | o_load | o_store | o_branch | o_jump);

    always_comb begin
        o_aluc = c_ALU_ADD;
        if (o_inst.op_sub || o_branch)
            o_aluc = c_ALU_SUB;
        else if (o_inst.op_and || o_inst.op_andi)
            o_aluc = c_ALU_AND;
        else if (o_inst.op_or || o_inst.op_ori)
            o_aluc = c_ALU_OR;
        else if (o_inst.op_xor || o_inst.op_xori)
            o_aluc = c_ALU_XOR;
        else if (o_inst.op_nor)
            o_aluc = c_ALU_NOR;
        else if (o_inst.op_lui)
            o_aluc = c_ALU_LUI;
        else if (o_inst.op_sll)
            o_aluc = c_ALU_SLL;
        else if (o_inst.op_srl)
            o_aluc = c_ALU_SRL;
        else if (o_inst.op_sra)
            o_aluc = c_ALU_SRA;
        else if (o_inst.op_slt || o_inst.op_slti)
            o_aluc = c_ALU_SLT;
        else if (o_inst.op_sltu || o_inst.op_sltiu)
            o_aluc = c_ALU_SLTU;
    end

endmodule
`default_nettype wire

// File: rtl/mc_cu.sv
`default_nettype none
//============================================================================
// Module   : mc_cu
// Brief    : Multicycle IF/ID/EXE/MEM/WB control FSM with memory-ready handshake.
// Revision : 1.0  initial release
//============================================================================
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit EXT_ISA     = 1'b1,
    parameter int ALUC_W      = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic              z,
    input  logic              mem_ready,
    output logic              wpc,
    output logic              wir,
    output logic              wmem,
    output logic              wreg,
    output logic              iord,
    output logic              regrt,
    output logic              m2reg,
    output logic              jal,
    output logic              sext,
    output logic              shift,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [ALUC_W-1:0] aluc,
    output logic [1:0]        pcsource,
    output logic [2:0]        state,
    output logic              illegal
);

    state_t     r_state;
    state_t     w_next;
    inst_t      w_inst;
    logic [3:0] w_dec_aluc;
    logic       w_dec_regrt, w_dec_sext, w_dec_shift;
    logic       w_dec_rtype, w_dec_itype, w_dec_load, w_dec_store;
    logic       w_dec_branch, w_dec_jump, w_dec_illegal;
    logic       w_mem_ready;
    logic       w_wpc, w_wir, w_wmem, w_wreg;
    logic [3:0] w_aluc;
    logic       w_unused;

    mc_cu_decode #(
        .EXT_ISA (EXT_ISA)
    ) u_decode (
        .i_op      (op),
        .i_func    (func),
        .o_inst    (w_inst),
        .o_aluc    (w_dec_aluc),
        .o_regrt   (w_dec_regrt),
        .o_sext    (w_dec_sext),
        .o_shift   (w_dec_shift),
        .o_rtype   (w_dec_rtype),
        .o_itype   (w_dec_itype),
        .o_load    (w_dec_load),
        .o_store   (w_dec_store),
        .o_branch  (w_dec_branch),
        .o_jump    (w_dec_jump),
        .o_illegal (w_dec_illegal)
    );

    assign w_unused = ^{w_inst, w_dec_itype, w_dec_jump};

    generate
        if (MEM_WAIT_EN) begin : g_mem_wait
            assign w_mem_ready = mem_ready;
        end else begin : g_no_mem_wait
            assign w_mem_ready = 1'b1;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_IF;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = S_IF;
        w_wpc    = 1'b0;
        w_wir    = 1'b0;
        w_wmem   = 1'b0;
        w_wreg   = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = c_ALUB_REG;
        w_aluc   = c_ALU_ADD;
        pcsource = c_PC_ALU;
        illegal  = 1'b0;
        case (r_state)
            S_IF: begin
                alusrcb = c_ALUB_FOUR;
                if (w_mem_ready) begin
                    w_wir  = 1'b1;
                    w_wpc  = 1'b1;
                    w_next = S_ID;
                end else begin
                    w_next = S_IF;
                end
            end
            S_ID: begin
                // ALU precomputes the branch target while the register file is read
                alusrcb = c_ALUB_IMM4;
                sext    = 1'b1;
                if (w_dec_illegal) begin
                    illegal = 1'b1;
                    w_next  = S_IF;
                end else if (w_inst.op_j || w_inst.op_jal) begin
                    w_wpc    = 1'b1;
                    pcsource = c_PC_JUMP;
                    w_wreg   = w_inst.op_jal;
                    jal      = w_inst.op_jal;
                    w_next   = S_IF;
                end else if (w_inst.op_jr) begin
                    w_wpc    = 1'b1;
                    pcsource = c_PC_REGA;
                    w_next   = S_IF;
                end else begin
                    w_next = S_EXE;
                end
            end
            S_EXE: begin
                shift   = w_dec_shift;
                alusrca = ~w_dec_shift;
                alusrcb = (w_dec_rtype || w_dec_branch) ? c_ALUB_REG : c_ALUB_IMM;
                w_aluc  = w_dec_aluc;
                sext    = w_dec_sext;
                if (w_dec_branch) begin
                    w_wpc    = (w_inst.op_beq & z) | (w_inst.op_bne & ~z);
                    pcsource = c_PC_ALUOUT;
                    w_next   = S_IF;
                end else if (w_dec_load || w_dec_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                iord   = 1'b1;
                w_wmem = w_dec_store;
                if (w_mem_ready)
                    w_next = w_dec_store ? S_IF : S_WB;
                else
                    w_next = S_MEM;
            end
            S_WB: begin
                w_wreg = 1'b1;
                m2reg  = w_dec_load;
                regrt  = w_dec_regrt;
                w_next = S_IF;
            end
            default: w_next = S_IF;
        endcase
    end

    // Write strobes are forced off while reset is held, independent of inputs
    assign wpc   = w_wpc  & ~reset;
    assign wir   = w_wir  & ~reset;
    assign wmem  = w_wmem & ~reset;
    assign wreg  = w_wreg & ~reset;
    assign state = r_state;

    generate
        if (ALUC_W > 4) begin : g_aluc_wide
            assign aluc = {{(ALUC_W-4){1'b0}}, w_aluc};
        end else begin : g_aluc_exact
            assign aluc = w_aluc[ALUC_W-1:0];
        end
    endgenerate

endmodule
`default_nettype wire
